// File: rtl/alu_muldiv_unit.sv
// Registered ALU with optional iterative shift-add multiplier and signed restoring divider.
// Define MULDIV_EN to build the MUL/DIV datapath; otherwise codes 7 and 8 behave as unsupported.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;

`ifdef MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic [WIDTH-1:0] alu_d;

    always_comb begin
        alu_d = '0;
        case (ALUOp)
            OP_ADD:  alu_d = SrcA + SrcB;
            OP_SUB:  alu_d = SrcA - SrcB;
            OP_XOR:  alu_d = SrcA ^ SrcB;
            OP_OR:   alu_d = SrcA | SrcB;
            OP_AND:  alu_d = SrcA & SrcB;
            OP_SLL:  alu_d = SrcA << SrcB[4:0];
            OP_SRL:  alu_d = SrcA >> SrcB[4:0];
            default: alu_d = '0;
        endcase
    end

`ifdef MULDIV_EN
    logic             busy_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsor_q;
    logic             neg_q;

    logic [WIDTH-1:0] mul_sum_d;
    logic [WIDTH:0]   rem_shift_d;
    logic [WIDTH:0]   diff_d;
    logic             quo_bit_d;
    logic [WIDTH-1:0] rem_next_d;
    logic [WIDTH-1:0] quo_next_d;
    logic [WIDTH-1:0] abs_a_d;
    logic [WIDTH-1:0] abs_b_d;
    logic             div_ovf_d;

    always_comb begin
        mul_sum_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_shift_d = {rem_q, quo_q[WIDTH-1]};
        diff_d      = rem_shift_d - {1'b0, dsor_q};
        quo_bit_d   = ~diff_d[WIDTH];
        rem_next_d  = quo_bit_d ? diff_d[WIDTH-1:0] : rem_shift_d[WIDTH-1:0];
        quo_next_d  = {quo_q[WIDTH-2:0], quo_bit_d};
        // Magnitude of the most negative value is still correct read as unsigned.
        abs_a_d     = SrcA[WIDTH-1] ? -SrcA : SrcA;
        abs_b_d     = SrcB[WIDTH-1] ? -SrcB : SrcB;
        div_ovf_d   = (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_EN
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsor_q   <= '0;
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifdef MULDIV_EN
                S_MUL: begin
                    acc_q    <= mul_sum_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= mul_sum_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_next_d;
                    quo_q <= quo_next_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= neg_q ? -quo_next_d : quo_next_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
`ifdef MULDIV_EN
                        if (ALUOp == OP_MUL) begin
                            acc_q    <= '0;
                            mcand_q  <= SrcA;
                            mplier_q <= SrcB;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else if (ALUOp == OP_DIV && SrcB == '0) begin
                            result_q <= '1;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (ALUOp == OP_DIV && div_ovf_d) begin
                            result_q <= SrcA;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (ALUOp == OP_DIV) begin
                            rem_q   <= '0;
                            quo_q   <= abs_a_d;
                            dsor_q  <= abs_b_d;
                            neg_q   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_DIV;
                        end else
`endif
                        begin
                            result_q <= alu_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign ALUResult = result_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit; expectations follow the MULDIV_EN setting of the build.
module tb_alu_muldiv_unit;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ALUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ALUOp(ALUOp),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .ALUResult(ALUResult),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Launches one operation, scrambles the inputs after acceptance and waits for done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt, output bit ovl);
        ALUOp = op; SrcA = a; SrcB = b; start = 1'b1;
        step();
        start = 1'b0; ALUOp = 4'd2; SrcA = ~a; SrcB = ~b;
        lat = 1; bcnt = 0; ovl = 1'b0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        if (busy) ovl = 1'b1;
        if (!done) lat = -1;
        res = ALUResult;
        $display("txn op=%0d a=%h b=%h -> res=%h lat=%0d busy_cycles=%0d", op, a, b, res, lat, bcnt);
    endtask

    initial begin
        logic [31:0] res;
        int lat, bcnt, dcnt;
        bit ovl;

        add_vec(4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        add_vec(4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1);
        add_vec(4'd1, 32'h0000000A, 32'h00000003, 32'h00000007, 1);
        add_vec(4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
        add_vec(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        add_vec(4'd3, 32'h00FF0000, 32'h000000FF, 32'h00FF00FF, 1);
        add_vec(4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        add_vec(4'd5, 32'h00000001, 32'h00000024, 32'h00000010, 1);
        add_vec(4'd5, 32'h00000003, 32'h0000001F, 32'h80000000, 1);
        add_vec(4'd6, 32'h80000000, 32'h0000001F, 32'h00000001, 1);
        add_vec(4'd6, 32'h80000000, 32'h00000004, 32'h08000000, 1);
        add_vec(4'd9, 32'h12345678, 32'h11111111, 32'h00000000, 1);
        add_vec(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
        add_vec(4'd7, 32'h00010000, 32'h00010001, MD ? 32'h00010000 : 32'h0, MD ? 33 : 1);
        add_vec(4'd7, 32'h00000003, 32'h00000004, MD ? 32'h0000000C : 32'h0, MD ? 33 : 1);
        add_vec(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'h00000001 : 32'h0, MD ? 33 : 1);
        add_vec(4'd7, 32'h12345678, 32'h00000000, 32'h00000000, MD ? 33 : 1);
        add_vec(4'd8, 32'hFFFFFFF9, 32'h00000002, MD ? 32'hFFFFFFFD : 32'h0, MD ? 33 : 1);
        add_vec(4'd8, 32'h00000007, 32'hFFFFFFFE, MD ? 32'hFFFFFFFD : 32'h0, MD ? 33 : 1);
        add_vec(4'd8, 32'hFFFFFFF8, 32'hFFFFFFFE, MD ? 32'h00000004 : 32'h0, MD ? 33 : 1);
        add_vec(4'd8, 32'h00000064, 32'h00000007, MD ? 32'h0000000E : 32'h0, MD ? 33 : 1);
        add_vec(4'd8, 32'h80000000, 32'h00000002, MD ? 32'hC0000000 : 32'h0, MD ? 33 : 1);
        add_vec(4'd8, 32'h00000003, 32'h00000005, 32'h00000000, MD ? 33 : 1);
        add_vec(4'd8, 32'h00000005, 32'h00000000, MD ? 32'hFFFFFFFF : 32'h0, 1);
        add_vec(4'd8, 32'h80000000, 32'hFFFFFFFF, MD ? 32'h80000000 : 32'h0, 1);
        add_vec(4'd8, 32'h80000000, 32'h00000000, MD ? 32'hFFFFFFFF : 32'h0, 1);

        rst = 1'b1; start = 1'b0; ALUOp = 4'd0; SrcA = '0; SrcB = '0;
        step();
        step();
        check("reset_result", ALUResult, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, ovl);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, (vecs[i].lat == 33) ? 32 : 0);
            check($sformatf("v%0d_busy_at_done", i), {31'b0, ovl}, 32'h0);
            step();
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
            check($sformatf("v%0d_held", i), ALUResult, vecs[i].exp);
        end

`ifdef MULDIV_EN
        // Start pulses arriving mid-multiply must not disturb it.
        ALUOp = 4'd7; SrcA = 32'h00010000; SrcB = 32'h00010001; start = 1'b1;
        step();
        start = 1'b0; lat = 1; bcnt = 0; ovl = 1'b0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            if (lat == 5) begin
                start = 1'b1; ALUOp = 4'd0; SrcA = 32'h1; SrcB = 32'h1;
            end else if (lat == 20) begin
                start = 1'b1; ALUOp = 4'd8;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        $display("txn mul_ignore_start res=%h lat=%0d busy_cycles=%0d", ALUResult, lat, bcnt);
        check("ign_latency", lat, 33);
        check("ign_result", ALUResult, 32'h00010000);
        check("ign_busy_cycles", bcnt, 32);
        check("ign_busy_at_done", {31'b0, busy}, 32'h0);
        step();
        check("ign_done_pulse", {31'b0, done}, 32'h0);
        check("ign_held", ALUResult, 32'h00010000);
`endif

        // Asynchronous reset, mid-multiply when the iterative unit is present.
        run_op(4'd0, 32'h00001234, 32'h0, res, lat, bcnt, ovl);
        check("pre_rst_result", res, 32'h00001234);
`ifdef MULDIV_EN
        ALUOp = 4'd7; SrcA = 32'h3; SrcB = 32'h4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("midop_busy", {31'b0, busy}, 32'h1);
`endif
        #2 rst = 1'b1;
        #1;
        $display("txn async_reset res=%h busy=%0d done=%0d", ALUResult, busy, done);
        check("rst_now_result", ALUResult, 32'h0);
        check("rst_now_busy", {31'b0, busy}, 32'h0);
        check("rst_now_done", {31'b0, done}, 32'h0);
        step();
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            step();
            if (done || busy) dcnt++;
        end
        check("post_rst_quiet", dcnt, 0);
        run_op(4'd0, 32'h2, 32'h3, res, lat, bcnt, ovl);
        check("post_rst_add", res, 32'h5);
        check("post_rst_latency", lat, 1);

        // Back-to-back: start held high through the multiply, SUB taken in its DONE cycle.
        ALUOp = 4'd7; SrcA = 32'h3; SrcB = 32'h4; start = 1'b1;
        step();
        ALUOp = 4'd1; SrcA = 32'hA; SrcB = 32'h3;
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        $display("txn b2b_first res=%h lat=%0d", ALUResult, lat);
        check("b2b_latency", lat, MD ? 33 : 1);
        check("b2b_first_result", ALUResult, MD ? 32'hC : 32'h0);
        step();
        $display("txn b2b_second res=%h done=%0d", ALUResult, done);
        check("b2b_second_done", {31'b0, done}, 32'h1);
        check("b2b_second_result", ALUResult, 32'h7);
        start = 1'b0;
        step();
        check("b2b_end_done", {31'b0, done}, 32'h0);
        check("b2b_end_held", ALUResult, 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request; sampled only when state is IDLE or DONE.
REQ-005 SHALL have port ALUOp  input  4  operation code from ALU decoder: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 MUL, 8 DIV, all others NA.
REQ-006 SHALL have port SrcA  input  32  operand A.
REQ-007 SHALL have port SrcB  input  32  operand B.
REQ-008 SHALL have port ALUResult  output  32  registered result, held until next accepted start.
REQ-009 SHALL have port busy  output  1  high while an iterative MUL/DIV is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when ALUResult becomes valid.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-012 SHALL accept start in IDLE or DONE; start in MUL/DIV SHALL be ignored, with no effect on operation in progress.
REQ-013 SHALL latch ALUOp, SrcA and SrcB on acceptance; later input changes SHALL not affect the operation.
REQ-014 ADD/SUB/XOR/OR/AND SHALL produce 32-bit wrap-around results, SLL/SRL shift SrcA by SrcB[4:0] (SRL logical, zero fill); these SHALL go to DONE with result registered, done high in the cycle after acceptance.
REQ-015 NA codes SHALL give ALUResult 0 with the same 1-cycle latency.
REQ-016 MUL SHALL be iterative shift-add, one multiplier bit per cycle, 32 cycles in state MUL, result = low 32 bits of SrcA*SrcB (sign-agnostic).
REQ-017 DIV SHALL be signed (two's complement) quotient truncated toward zero, via 32-cycle restoring division on magnitudes, quotient negated when operand signs differ.
REQ-018 DIV with SrcB = 0 SHALL bypass iteration and give 32'hFFFFFFFF with 1-cycle latency.
REQ-019 DIV with SrcA = 32'h80000000 and SrcB = 32'hFFFFFFFF SHALL bypass iteration and give 32'h80000000 with 1-cycle latency.
REQ-020 For iterative MUL/DIV accepted in cycle N: busy high cycles N+1..N+32, done high cycle N+33, busy low in done cycle.
REQ-021 DONE SHALL last exactly one cycle, returning to IDLE unless start is asserted, in which case the new operation is accepted (back-to-back).
REQ-022 done and busy SHALL never be high simultaneously.

Reset
REQ-023 rst high SHALL immediately force state IDLE, ALUResult 0, busy 0, done 0, clear iteration counter and internal registers, including mid-operation.
REQ-024 After rst release, the first rising edge with start high SHALL be accepted normally.

Configuration
REQ-025 Macro MULDIV_EN defined: MUL and DIV behave per REQ-016..REQ-020.
REQ-026 MULDIV_EN undefined: MUL/DIV logic and states SHALL be compiled out; codes 7 and 8 SHALL behave as NA (result 0, 1-cycle), busy tied 0.

Verification
REQ-027 ADD 32'hFFFFFFFF + 1, start cycle N -> done cycle N+1, ALUResult 0, busy never high.
REQ-028 SLL SrcA=1, SrcB=32'h00000024 -> ALUResult 32'h00000010 (shift 4); SRL SrcA=32'h80000000, SrcB=31 -> 1.
REQ-029 MUL 32'h00010000 x 32'h00010001 (MULDIV_EN) -> busy N+1..N+32, done N+33, ALUResult 32'h00010000; start pulses during busy ignored.
REQ-030 DIV -7/2 -> 32'hFFFFFFFD at N+33; DIV 5/0 -> 32'hFFFFFFFF at N+1; DIV 32'h80000000/-1 -> 32'h80000000 at N+1.
REQ-031 rst asserted at cycle N+10 of a MUL -> outputs 0 immediately, no done pulse; next ADD 2+3 -> 5 after 1 cycle.
REQ-032 Back-to-back: start held through DONE of MUL 3x4 then SUB 10-3 -> results 12 then 7, each with one done pulse.
